// File: rtl/serial_lut_programmer_if.sv
// Host-side bus of the serial LUT programmer: the parallel table-write port,
// the frame request, and the registered serial frame outputs.
interface serial_lut_programmer_if #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 3
);
  logic                 wr_en;
  logic [IN_WIDTH-1:0]  wr_addr;
  logic [OUT_WIDTH-1:0] wr_data;
  logic                 start;
  logic                 sd;
  logic                 sclk;
  logic                 scs_n;
  logic                 busy;
  logic                 done;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  sd, sclk, scs_n, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output sd, sclk, scs_n, busy, done
  );
endinterface

// File: rtl/serial_lut_programmer.sv
// Shadow LUT table plus frame generator. On start the padded table image is
// snapshotted and shifted out MSB-first on sd/sclk/scs_n so the downstream
// shift register ends up holding exactly the shadow table.
module serial_lut_programmer #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 3,
  parameter int SHIFT_LEN = 2**(IN_WIDTH+OUT_WIDTH),
  parameter int CLK_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_lut_programmer_if.slave  bus
);
  localparam int ENTRIES = 2**IN_WIDTH;
  localparam int TBL_W   = ENTRIES*OUT_WIDTH;
  localparam int BW      = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

  state_t               state, state_d;
  logic [TBL_W-1:0]     shadow;
  logic [SHIFT_LEN-1:0] image;
  logic [SHIFT_LEN-1:0] shreg, shreg_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DW-1:0]        div_cnt, div_d;
  logic                 div_last;
  logic                 sd_q, sd_d;
  logic                 sclk_q, sclk_d;
  logic                 scs_n_q, scs_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign bus.sd    = sd_q;
  assign bus.sclk  = sclk_q;
  assign bus.scs_n = scs_n_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // Shadow table: writes land in any state; an in-flight frame uses its snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (bus.wr_en)
      shadow[bus.wr_addr*OUT_WIDTH +: OUT_WIDTH] <= bus.wr_data;
  end

  // Frame image: table in the low bits, zero padding above it.
  always_comb begin
    image              = '0;
    image[TBL_W-1:0]   = shadow;
  end

  // State and output registers; everything the target sees is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sd_q    <= 1'b0;
      sclk_q  <= 1'b0;
      scs_n_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_d;
      div_cnt <= div_d;
      sd_q    <= sd_d;
      sclk_q  <= sclk_d;
      scs_n_q <= scs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: each LOW/HIGH/TAIL phase lasts CLK_DIV cycles; sd only
  // advances on the HIGH->LOW transition so it is settled well before each rise.
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bit_d    = bit_cnt;
    div_d    = div_cnt;
    sd_d     = sd_q;
    sclk_d   = sclk_q;
    scs_n_d  = scs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_last = (div_cnt == DW'(CLK_DIV-1));
    case (state)
      IDLE: begin
        sd_d    = 1'b0;
        sclk_d  = 1'b0;
        scs_n_d = 1'b1;
        if (bus.start) begin
          shreg_d = image;
          sd_d    = image[SHIFT_LEN-1];
          scs_n_d = 1'b0;
          bit_d   = BW'(SHIFT_LEN-1);
          div_d   = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt == '0) begin
            state_d = TAIL;
          end else begin
            bit_d   = bit_cnt - 1'b1;
            shreg_d = {shreg[SHIFT_LEN-2:0], 1'b0};
            sd_d    = shreg[SHIFT_LEN-2];
            state_d = LOW;
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      TAIL: begin
        if (div_last) begin
          div_d   = '0;
          scs_n_d = 1'b1;
          sd_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_lut_programmer.sv
// Bench: behavioural serial target plus a table-level reference model.
module tb_serial_lut_programmer;
  localparam int IW = 4;
  localparam int OW = 3;
  localparam int NE = 16;
  localparam int SL = 128;
  localparam int CD = 2;
  localparam int FRAME_LOW = CD*(2*SL+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_lut_programmer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  serial_lut_programmer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_LEN(SL), .CLK_DIV(CD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference: what the host has written, and what the current frame should carry.
  logic [OW-1:0] ref_tbl [NE];
  logic [OW-1:0] exp_tbl [NE];

  // Target model and frame observers.
  logic [SL-1:0] tgt = '0;
  int  rise_cnt = 0, last_rises = 0, low_len = 0, last_low = 0;
  int  hi_len = 0, gap_len = 0, sd_age = 0, viol = 0, done_cnt = 0;
  logic prev_sclk = 1'b0, prev_sd = 1'b0, prev_scs = 1'b1, done_at_end = 1'b0;

  // Behavioural target: shift sd in on every sclk rise while cs_n is low,
  // and watch frame shape (lengths, gaps, sd setup before each rise).
  always @(negedge clk) begin
    if (bus.sd !== prev_sd) sd_age = 0; else sd_age++;
    if (bus.sclk && bus.scs_n) viol++;
    if (bus.sclk && !prev_sclk) begin
      if (!bus.scs_n) begin
        tgt = {tgt[SL-2:0], bus.sd};
        rise_cnt++;
      end
      if (sd_age < CD) viol++;
    end
    if (!bus.scs_n) begin
      if (prev_scs) begin
        gap_len  = hi_len;
        rise_cnt = 0;
        low_len  = 0;
      end
      low_len++;
    end else begin
      if (!prev_scs) begin
        last_low    = low_len;
        last_rises  = rise_cnt;
        done_at_end = bus.done;
        hi_len      = 0;
      end
      hi_len++;
    end
    if (bus.done) done_cnt++;
    prev_sclk = bus.sclk;
    prev_sd   = bus.sd;
    prev_scs  = bus.scs_n;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = IW'(addr);
    bus.wr_data = OW'(data);
    step();
    bus.wr_en   = 1'b0;
    ref_tbl[addr] = OW'(data);
  endtask

  task automatic snap();
    for (int i = 0; i < NE; i++) exp_tbl[i] = ref_tbl[i];
  endtask

  task automatic pulse_start();
    snap();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4*FRAME_LOW; i++) begin
      step();
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done, want done within %0d cycles", tag, 4*FRAME_LOW);
    end
  endtask

  task automatic wait_rises(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4*FRAME_LOW; i++) begin
      step();
      if (rise_cnt >= n) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s rise_timeout: got %0d rises, want %0d", tag, rise_cnt, n);
    end
  endtask

  task automatic check_frame(input string tag);
    logic [OW-1:0] got;
    int bad = 0;
    n_tests++;
    if (last_rises !== SL) begin
      n_fail++;
      $display("FAIL %s rises: got %0d want %0d", tag, last_rises, SL);
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s shape_violations: got %0d want 0", tag, viol);
    end
    n_tests++;
    if (tgt[SL-1:NE*OW] !== '0) begin
      n_fail++;
      $display("FAIL %s padding: got %h want 0", tag, tgt[SL-1:NE*OW]);
    end
    for (int i = 0; i < NE; i++) begin
      got = tgt[(i+1)*OW-1 -: OW];
      if (got !== exp_tbl[i]) begin
        bad++;
        $display("FAIL %s entry%0d: got %0d want %0d", tag, i, got, exp_tbl[i]);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({bus.sd, bus.sclk, bus.scs_n, bus.busy, bus.done} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_outputs: got sd,sclk,scs_n,busy,done=%b want 00100",
               {bus.sd, bus.sclk, bus.scs_n, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    step();
    pulse_start();
    wait_done("reset_frame");
    check_frame("reset_frame");
  endtask

  task automatic test_basic();
    wr(0, 3'b101);
    wr(15, 3'b011);
    pulse_start();
    wait_done("basic");
    check_frame("basic");
  endtask

  task automatic test_timing();
    int d0;
    wr(7, 6);
    bus.start = 1'b1;
    snap();
    step();
    bus.start = 1'b0;
    d0 = done_cnt;
    n_tests++;
    if (bus.scs_n !== 1'b0 || bus.busy !== 1'b1 || bus.sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL timing_start: got scs_n=%b busy=%b sclk=%b want 0 1 0", bus.scs_n, bus.busy, bus.sclk);
    end
    step();
    n_tests++;
    if (bus.sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL timing_low1: got sclk=%b want 0", bus.sclk);
    end
    step();
    n_tests++;
    if (bus.sclk !== 1'b1) begin
      n_fail++;
      $display("FAIL timing_first_rise: got sclk=%b want 1", bus.sclk);
    end
    wait_done("timing");
    n_tests++;
    if (last_low !== FRAME_LOW || done_at_end !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timing_frame: got low=%0d done_at_end=%b busy=%b want %0d 1 0",
               last_low, done_at_end, bus.busy, FRAME_LOW);
    end
    step();
    n_tests++;
    if (bus.done !== 1'b0 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL timing_done_pulse: got done=%b pulses=%0d want 0 1", bus.done, done_cnt - d0);
    end
    check_frame("timing");
  endtask

  task automatic test_busy_ignore();
    int d0, hi;
    wr(3, 2);
    pulse_start();
    d0 = done_cnt;
    wait_rises(60, "busy_ignore");
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = IW'(3);
    bus.wr_data = OW'(7);
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    ref_tbl[3] = 3'd7;
    wait_done("busy_ignore");
    check_frame("busy_ignore");
    hi = 0;
    repeat (20) begin
      step();
      if (bus.scs_n === 1'b1) hi++;
    end
    n_tests++;
    if (done_cnt - d0 !== 1 || hi !== 20) begin
      n_fail++;
      $display("FAIL busy_ignore_single: got frames=%0d idle=%0d want 1 20", done_cnt - d0, hi);
    end
    pulse_start();
    wait_done("busy_reload");
    check_frame("busy_reload");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 12; k++) wr($urandom_range(NE-1), $urandom_range(7));
      pulse_start();
      wait_done("random");
      check_frame($sformatf("random%0d", r));
    end
  endtask

  task automatic test_mid_reset();
    int r0;
    for (int i = 0; i < NE; i++) wr(i, $urandom_range(1, 7));
    pulse_start();
    wait_rises(40, "mid_reset");
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.sd, bus.sclk, bus.scs_n, bus.busy, bus.done} !== 5'b00100) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got sd,sclk,scs_n,busy,done=%b want 00100",
               {bus.sd, bus.sclk, bus.scs_n, bus.busy, bus.done});
    end
    r0 = rise_cnt;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (5) step();
    n_tests++;
    if (rise_cnt !== r0 || bus.sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got rises=%0d sclk=%b want %0d 0", rise_cnt, bus.sclk, r0);
    end
    for (int i = 0; i < NE; i++) ref_tbl[i] = '0;
    viol = 0;
    pulse_start();
    wait_done("mid_reset");
    check_frame("mid_reset_cleared");
  endtask

  task automatic test_back_to_back();
    wr(9, 5);
    wr(1, 4);
    snap();
    bus.start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done("b2b");
      if (f == 2) bus.start = 1'b0;
      check_frame($sformatf("b2b%0d", f));
      n_tests++;
      if (last_low !== FRAME_LOW) begin
        n_fail++;
        $display("FAIL b2b%0d_len: got %0d want %0d", f, last_low, FRAME_LOW);
      end
      if (f > 0) begin
        n_tests++;
        if (gap_len !== 1) begin
          n_fail++;
          $display("FAIL b2b%0d_gap: got %0d want 1", f, gap_len);
        end
      end
    end
    repeat (10) step();
    n_tests++;
    if (bus.scs_n !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got scs_n=%b busy=%b want 1 0", bus.scs_n, bus.busy);
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    for (int i = 0; i < NE; i++) ref_tbl[i] = '0;
    test_reset();
    test_basic();
    test_timing();
    test_busy_ignore();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
